// File: rtl/param_binary_counter.sv
// Up/down modulo-MOD counter paced by an internal PRESCALE clock-enable, with clear, wrap pulse and terminal count.
// Parallel load is built only when PARAM_BINARY_COUNTER_LOAD_EN is defined; otherwise load/load_val are ignored.
`timescale 1ns/1ps
module param_binary_counter #(
  parameter int WIDTH    = 8,
  parameter int MOD      = 256,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             count_down,
  input  logic             startstop,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] num_out,
  output logic             tc,
  output logic             wrap,
  output logic             slow_clock_en
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_CNT  = WIDTH'(MOD - 1);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             sce_q, sce_d;
  logic             step;
  logic             load_act;
  logic [WIDTH-1:0] load_clamped;

`ifdef PARAM_BINARY_COUNTER_LOAD_EN
  assign load_act     = load;
  assign load_clamped = (load_val > MAX_CNT) ? MAX_CNT : load_val;
`else
  logic unused_load;
  assign unused_load  = ^{load, load_val};
  assign load_act     = 1'b0;
  assign load_clamped = '0;
`endif

  assign step = sce_q && startstop;

  always_comb begin
    pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
    sce_d  = (pre_q == PRE_LAST);
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
      pre_d = '0;
      sce_d = 1'b0;
    end else if (load_act) begin
      cnt_d = load_clamped;
    end else if (step) begin
      if (count_down) begin
        if (cnt_q == '0) begin
          cnt_d  = MAX_CNT;
          wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end else begin
        if (cnt_q == MAX_CNT) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q  <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      sce_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      sce_q  <= sce_d;
    end
  end

  assign num_out       = cnt_q;
  assign wrap          = wrap_q;
  assign slow_clock_en = sce_q;
  assign tc            = count_down ? (cnt_q == '0) : (cnt_q == MAX_CNT);

endmodule

// File: doc/param_binary_counter.md
# param_binary_counter

Parametrised up/down binary counter with programmable modulus, built-in clock-enable prescaler, synchronous clear, parallel load and wrap reporting. It is the next-generation replacement for the fixed 8-bit nibble-chained counter: a single counter of any width, counting through `0..MOD-1`, paced by its own `slow_clock_en` tick from the one system clock. It drives display and timing logic in the lab designs.

## Interface
Parameters:
- `WIDTH`, default 8: counter width in bits.
- `MOD`, default 256: count modulus. Legal range is `2 <= MOD <= 2**WIDTH`.
- `PRESCALE`, default 1: system clocks per step tick. Legal range is `PRESCALE >= 1`.

Ports:
- `clk`, input, 1: single system clock, rising edge.
- `reset`, input, 1: asynchronous, active-low reset (asserted when 0).
- `count_down`, input, 1: 1 selects down-counting, 0 selects up-counting.
- `startstop`, input, 1: level run enable; 1 counts, 0 holds.
- `clear`, input, 1: synchronous clear.
- `load`, input, 1: synchronous parallel load.
- `load_val`, input, WIDTH: value to load.
- `num_out`, output, WIDTH: current count.
- `tc`, output, 1: terminal count (combinational).
- `wrap`, output, 1: one-cycle registered pulse after a wrap.
- `slow_clock_en`, output, 1: registered prescaler tick.

## Operation
- **Prescaler:**
  - Internal counter `pre` counts `0..PRESCALE-1` and is free-running, independent of `startstop`.
  - `slow_clock_en` is registered. It is 1 for exactly one cycle out of every PRESCALE cycles, set on the edge where `pre` wraps to 0.
  - With `PRESCALE=1`, `slow_clock_en` is constantly 1 after the first edge out of reset.
- **Step condition:** `step = slow_clock_en && startstop`, sampled at the rising edge.
- **Counting up:**
  - `num_out == MOD-1` goes to 0, and `wrap` is set to 1.
  - Otherwise `num_out` increments by 1.
- **Counting down:**
  - `num_out == 0` goes to `MOD-1`, and `wrap` is set to 1.
  - Otherwise `num_out` decrements by 1.
- **`wrap`:** 0 on any edge without a wrapping step.
- **`tc`:** `count_down ? (num_out == 0) : (num_out == MOD-1)`.
  - Combinational, independent of `startstop` and `slow_clock_en`.
  - Follows `count_down` in the same cycle.
- **Priority per edge:** `clear` > `load` > step.
  - **`clear`:** `num_out`, `pre`, `slow_clock_en` and `wrap` go to 0.
  - **`load`:** `num_out = (load_val > MOD-1) ? MOD-1 : load_val`.
    - `wrap` goes to 0.
    - The prescaler is unaffected.
    - A step coinciding with `load` is discarded.
- **Direction changes:** a change of `count_down` takes effect on the next step. No extra latency, no glitch on `num_out`.
- **All arithmetic** is WIDTH bits wide. `num_out` never leaves `0..MOD-1`.

## Timing
- **Reset values:** `num_out=0`, `pre=0`, `slow_clock_en=0`, `wrap=0`.
  - `tc` is 0 in up mode, 1 in down mode.
- **Reset assertion** takes effect immediately, without a clock, even mid-count or mid-load.
- **After reset release:**
  - The first `slow_clock_en` pulse is high following the PRESCALE-th rising edge.
  - The first step lands on the next edge.
- **Step latency:** `num_out` updates on the edge where `slow_clock_en && startstop` is sampled high.
- **Wrap:** `wrap` is high in the cycle immediately after the wrapping edge, for one cycle only.
- **`startstop` deasserted** during a `slow_clock_en` cycle: no step, and the tick is lost, not queued.
- **Load / clear:** both take effect on the next edge, with 1-cycle latency to `num_out`.

## Configuration
- **Macro:** `PARAM_BINARY_COUNTER_LOAD_EN`.
- **Defined:** `load` and `load_val` behave as described above.
- **Undefined:**
  - The load logic is not synthesised.
  - `load` and `load_val` ports remain present but are ignored.
  - Priority reduces to `clear` > step.
  - The load test is skipped.

## Test plan
- **Reset and first step:** WIDTH=8, MOD=256, PRESCALE=1, `startstop=1`, up mode, release `reset` → `num_out` 0 for two edges, then 1, 2, 3…; `tc=0`.
- **Up wrap:** MOD=10, up mode, run from 0 → `num_out` runs 0..9 then 0. `tc=1` while at 9. `wrap` is high for exactly one cycle after 9→0.
- **Down wrap and direction switch:**
  - Down mode from 0 → 9, 8, … with a `wrap` pulse.
  - Switch to up mode at 7 → next step gives 8; `tc` follows `count_down` in the same cycle.
- **Prescaler and hold:**
  - PRESCALE=4 → `slow_clock_en` high 1 cycle in 4, and `num_out` advances once per 4 clocks.
  - `startstop=0` for 12 clocks → `num_out` holds and `slow_clock_en` keeps pulsing.
- **Clear/load priority and clamp:**
  - MOD=10, `load=1`, `load_val=25` → `num_out=9`.
  - `clear=1` with `load=1` and a step on the same edge → `num_out=0`, `wrap=0`.
- **Asynchronous reset mid-count:** assert `reset=0` between clock edges at `num_out=5` → outputs go to reset values immediately, before the next edge.
